mag_comp_serial: RTL and testbench

- Parametrised, digit-serial magnitude comparator. Generalises the 4-bit combinational comparator to any operand width.
- Compares two WIDTH-bit operands MSB-first, DIGIT bits per clock, with optional early termination and a signed/unsigned mode.
- Used where a wide parallel compare is too costly in area or timing. Controlled by a start/busy/done handshake; results are registered.

---
 rtl/mag_comp_serial.sv | 130 +++++++++++++
 tb/tb_mag_comp_serial.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mag_comp_serial.sv
// mag_comp_serial
//   Digit-serial magnitude comparator. Two WIDTH-bit operands are compared
//   MSB-first, DIGIT bits per clock, behind a start/busy/done handshake.
//   Signed operands are mapped to offset binary by flipping the MSB, so
//   the serial engine only ever performs an unsigned compare.
//
//   WIDTH must be a multiple of DIGIT; N = WIDTH/DIGIT digits per compare.
//   EARLY_EXIT=1 stops at the first differing digit. EARLY_EXIT=0 always
//   walks all N digits, giving data-independent latency.
//
// Ports
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   start        compare request, accepted in IDLE or DONE
//   a, b         operands, captured on the accept edge
//   signed_mode  1 = two's complement, 0 = unsigned; captured with operands
//   busy         high while comparing
//   done         one-cycle pulse after a result is written
//   eq, gt, lt   registered result of the last compare (exactly one high)
//   cycles       digits examined by the last compare
//
// state | meaning
// IDLE  | waiting for start
// CMP   | consuming one digit per clock
// DONE  | result valid, done pulse; start here is accepted back-to-back
module mag_comp_serial #(
  parameter  int WIDTH      = 8,
  parameter  int DIGIT      = 2,
  parameter  int EARLY_EXIT = 1,
  localparam int N          = WIDTH / DIGIT,
  localparam int CW         = $clog2(N + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             gt,
  output logic             lt,
  output logic [CW-1:0]    cycles
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CW-1:0]    N_C      = CW'(N);
  localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sa, sb;
  logic [CW-1:0]    cnt;
  logic             found, found_gt;

  logic [DIGIT-1:0] dig_a, dig_b;
  logic             dig_diff, dig_gt;
  logic [CW-1:0]    cnt_inc;
  logic             last_digit, cmp_last, accept;

  assign dig_a      = sa[WIDTH-1 -: DIGIT];
  assign dig_b      = sb[WIDTH-1 -: DIGIT];
  assign dig_diff   = (dig_a != dig_b);
  assign dig_gt     = (dig_a > dig_b);
  assign cnt_inc    = cnt + 1'b1;
  assign last_digit = (cnt_inc == N_C);
  // With early exit, found is never set while still in CMP, so the current
  // digit alone decides the exit.
  assign cmp_last   = (EARLY_EXIT != 0) ? (last_digit || dig_diff) : last_digit;
  assign accept     = start && (state != CMP);

  assign busy = (state == CMP);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CMP;
      CMP:     if (cmp_last) state_nxt = DONE;
      DONE:    state_nxt = start ? CMP : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa       <= '0;
      sb       <= '0;
      cnt      <= '0;
      found    <= 1'b0;
      found_gt <= 1'b0;
      eq       <= 1'b0;
      gt       <= 1'b0;
      lt       <= 1'b0;
      cycles   <= '0;
    end else if (accept) begin
      sa       <= a ^ (signed_mode ? MSB_MASK : '0);
      sb       <= b ^ (signed_mode ? MSB_MASK : '0);
      cnt      <= '0;
      found    <= 1'b0;
      found_gt <= 1'b0;
    end else if (state == CMP) begin
      cnt <= cnt_inc;
      sa  <= sa << DIGIT;
      sb  <= sb << DIGIT;
      if (!found && dig_diff) begin
        found    <= 1'b1;
        found_gt <= dig_gt;
      end
      if (cmp_last) begin
        // The first differing digit wins; later digits never override it.
        eq     <= !(found || dig_diff);
        gt     <= found ? found_gt  : (dig_diff && dig_gt);
        lt     <= found ? !found_gt : (dig_diff && !dig_gt);
        cycles <= cnt_inc;
      end
    end
  end

endmodule

// File: tb/tb_mag_comp_serial.sv
module tb_mag_comp_serial;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_e, start_f;
  logic [7:0] a, b;
  logic       signed_mode;

  logic       busy_e, done_e, eq_e, gt_e, lt_e;
  logic [2:0] cyc_e;
  logic       busy_f, done_f, eq_f, gt_f, lt_f;
  logic [2:0] cyc_f;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mag_comp_serial #(.WIDTH(8), .DIGIT(2), .EARLY_EXIT(1)) dut_e (
    .clk(clk), .rst_n(rst_n), .start(start_e), .a(a), .b(b),
    .signed_mode(signed_mode), .busy(busy_e), .done(done_e),
    .eq(eq_e), .gt(gt_e), .lt(lt_e), .cycles(cyc_e)
  );

  mag_comp_serial #(.WIDTH(8), .DIGIT(2), .EARLY_EXIT(0)) dut_f (
    .clk(clk), .rst_n(rst_n), .start(start_f), .a(a), .b(b),
    .signed_mode(signed_mode), .busy(busy_f), .done(done_f),
    .eq(eq_f), .gt(gt_f), .lt(lt_f), .cycles(cyc_f)
  );

  // Stimulus only: called 1 ns after a rising edge, issues start for one
  // edge on the selected DUT (0 = early exit, 1 = full walk), then counts
  // edges until done appears. k = -1 if done never arrives.
  task automatic run_op(input bit sel, input logic [7:0] ta, input logic [7:0] tb_v,
                        input logic sm, output int k, output int nbusy);
    a = ta; b = tb_v; signed_mode = sm;
    if (sel) start_f = 1'b1; else start_e = 1'b1;
    @(posedge clk); #1;
    start_e = 1'b0; start_f = 1'b0;
    k = -1; nbusy = 0;
    for (int i = 1; i <= 20; i++) begin
      if (sel ? busy_f : busy_e) nbusy++;
      @(posedge clk); #1;
      if (sel ? done_f : done_e) begin
        k = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start_e = 1'b0; start_f = 1'b0;
    a = '0; b = '0; signed_mode = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({busy_e, done_e, eq_e, gt_e, lt_e, cyc_e} !== 8'b0) begin
      miscompares++;
      $display("FAIL reset_e: got %b want 00000000", {busy_e, done_e, eq_e, gt_e, lt_e, cyc_e});
    end
    vectors++;
    if ({busy_f, done_f, eq_f, gt_f, lt_f, cyc_f} !== 8'b0) begin
      miscompares++;
      $display("FAIL reset_f: got %b want 00000000", {busy_f, done_f, eq_f, gt_f, lt_f, cyc_f});
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_unsigned_early;
    int k, nb;
    run_op(1'b0, 8'hD0, 8'hA0, 1'b0, k, nb);
    vectors++;
    if (k !== 1) begin
      miscompares++;
      $display("FAIL d0_a0_latency: got %0d want 1", k);
    end
    vectors++;
    if ({eq_e, gt_e, lt_e, cyc_e} !== {3'b010, 3'd1}) begin
      miscompares++;
      $display("FAIL d0_a0_result: eq/gt/lt/cyc got %b want 010001", {eq_e, gt_e, lt_e, cyc_e});
    end
    @(posedge clk); #1;
    vectors++;
    if (done_e !== 1'b0) begin
      miscompares++;
      $display("FAIL d0_a0_done_width: done got %b want 0", done_e);
    end

    run_op(1'b0, 8'hC5, 8'hE5, 1'b0, k, nb);
    vectors++;
    if (k !== 2 || nb !== 2) begin
      miscompares++;
      $display("FAIL c5_e5_timing: latency %0d busy %0d want 2 2", k, nb);
    end
    vectors++;
    if ({eq_e, gt_e, lt_e, cyc_e} !== {3'b001, 3'd2}) begin
      miscompares++;
      $display("FAIL c5_e5_result: got %b want 001010", {eq_e, gt_e, lt_e, cyc_e});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_equal;
    int k, nb;
    run_op(1'b0, 8'h11, 8'h11, 1'b0, k, nb);
    vectors++;
    if (k !== 4 || nb !== 4) begin
      miscompares++;
      $display("FAIL eq_11_timing: latency %0d busy %0d want 4 4", k, nb);
    end
    vectors++;
    if ({eq_e, gt_e, lt_e, cyc_e} !== {3'b100, 3'd4}) begin
      miscompares++;
      $display("FAIL eq_11_result: got %b want 100100", {eq_e, gt_e, lt_e, cyc_e});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_modes;
    int k, nb;
    // Results must hold (not clear) once a new start is accepted.
    a = 8'h80; b = 8'h7F; signed_mode = 1'b1; start_e = 1'b1;
    @(posedge clk); #1;
    start_e = 1'b0;
    vectors++;
    if ({busy_e, eq_e, gt_e, lt_e, cyc_e} !== {4'b1100, 3'd4}) begin
      miscompares++;
      $display("FAIL hold_on_start: got %b want 1100100", {busy_e, eq_e, gt_e, lt_e, cyc_e});
    end
    @(posedge clk); #1;
    vectors++;
    if ({done_e, eq_e, gt_e, lt_e, cyc_e} !== {4'b1001, 3'd1}) begin
      miscompares++;
      $display("FAIL s80_7f_signed: got %b want 1001001", {done_e, eq_e, gt_e, lt_e, cyc_e});
    end
    @(posedge clk); #1;

    run_op(1'b0, 8'h80, 8'h7F, 1'b0, k, nb);
    vectors++;
    if (k !== 1 || {eq_e, gt_e, lt_e, cyc_e} !== {3'b010, 3'd1}) begin
      miscompares++;
      $display("FAIL u80_7f_unsigned: lat %0d res %b want 1 010001", k, {eq_e, gt_e, lt_e, cyc_e});
    end
    @(posedge clk); #1;

    run_op(1'b0, 8'hFF, 8'hFE, 1'b1, k, nb);
    vectors++;
    if (k !== 4 || {eq_e, gt_e, lt_e, cyc_e} !== {3'b010, 3'd4}) begin
      miscompares++;
      $display("FAIL sff_fe_signed: lat %0d res %b want 4 010100", k, {eq_e, gt_e, lt_e, cyc_e});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_full_walk;
    int k, nb;
    run_op(1'b1, 8'hD0, 8'hA0, 1'b0, k, nb);
    vectors++;
    if (k !== 4 || nb !== 4) begin
      miscompares++;
      $display("FAIL full_d0_a0_timing: latency %0d busy %0d want 4 4", k, nb);
    end
    vectors++;
    if ({eq_f, gt_f, lt_f, cyc_f} !== {3'b010, 3'd4}) begin
      miscompares++;
      $display("FAIL full_d0_a0_result: got %b want 010100", {eq_f, gt_f, lt_f, cyc_f});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    int k, nb;
    // 0x11 vs 0x22 differs first at digit 2 (lt); a start with inverted
    // operands during busy must be ignored.
    a = 8'h11; b = 8'h22; signed_mode = 1'b0; start_f = 1'b1;
    @(posedge clk); #1;
    start_f = 1'b0;
    @(posedge clk); #1;
    a = 8'hFF; b = 8'h00; start_f = 1'b1;
    @(posedge clk); #1;
    start_f = 1'b0;
    k = -1;
    for (int i = 3; i <= 20; i++) begin
      @(posedge clk); #1;
      if (done_f) begin
        k = i;
        break;
      end
    end
    vectors++;
    if (k !== 4 || {eq_f, gt_f, lt_f, cyc_f} !== {3'b001, 3'd4}) begin
      miscompares++;
      $display("FAIL ignore_busy_start: lat %0d res %b want 4 001100", k, {eq_f, gt_f, lt_f, cyc_f});
    end

    // Still in the DONE cycle: this start is accepted back-to-back.
    run_op(1'b1, 8'h3C, 8'h3D, 1'b0, k, nb);
    vectors++;
    if (k !== 4 || nb !== 4 || {eq_f, gt_f, lt_f, cyc_f} !== {3'b001, 3'd4}) begin
      miscompares++;
      $display("FAIL back_to_back: lat %0d busy %0d res %b want 4 4 001100",
               k, nb, {eq_f, gt_f, lt_f, cyc_f});
    end
    @(posedge clk); #1;
    vectors++;
    if ({busy_f, done_f} !== 2'b00) begin
      miscompares++;
      $display("FAIL b2b_return_idle: busy/done got %b want 00", {busy_f, done_f});
    end
  endtask

  task automatic test_reset_mid_op;
    int k, nb;
    int seen_done;
    run_op(1'b0, 8'hD0, 8'hA0, 1'b0, k, nb);
    @(posedge clk); #1;
    a = 8'h11; b = 8'h11; start_e = 1'b1;
    @(posedge clk); #1;
    start_e = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({busy_e, done_e, eq_e, gt_e, lt_e, cyc_e} !== 8'b0) begin
      miscompares++;
      $display("FAIL reset_mid_op: got %b want 00000000", {busy_e, done_e, eq_e, gt_e, lt_e, cyc_e});
    end
    seen_done = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done_e) seen_done++;
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      if (done_e) seen_done++;
    end
    vectors++;
    if (seen_done !== 0) begin
      miscompares++;
      $display("FAIL reset_no_done: done pulses %0d want 0", seen_done);
    end
    run_op(1'b0, 8'h33, 8'h33, 1'b0, k, nb);
    vectors++;
    if (k !== 4 || {eq_e, gt_e, lt_e, cyc_e} !== {3'b100, 3'd4}) begin
      miscompares++;
      $display("FAIL after_reset_33: lat %0d res %b want 4 100100", k, {eq_e, gt_e, lt_e, cyc_e});
    end
  endtask

  initial begin
    test_reset();
    test_unsigned_early();
    test_equal();
    test_modes();
    test_full_walk();
    test_back_to_back();
    test_reset_mid_op();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
